// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_sup_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset, reset value 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor in the refclk domain.
// Optional lock-loss counter enabled by defining PLL_SUP_LOSS_COUNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 74000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       rearm,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       fail,
  output logic [2:0] state
`ifdef PLL_SUP_LOSS_COUNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

  localparam int MAX_CYC = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int RTY_W   = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;

  logic           locked_s;
  pll_sup_state_e state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [RTY_W-1:0] retries_r;

  sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  assign state = state_r;

  // Supervisor FSM; outputs are registered alongside the next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RESET_PLL;
      cnt_r     <= {CNT_W{1'b0}};
      retries_r <= {RTY_W{1'b0}};
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= {CNT_W{1'b0}};
            pll_rst <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen in the timeout cycle takes priority over a retry.
          if (locked_s) begin
            state_r <= ST_STABLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            pll_rst <= 1'b1;
            if (retries_r != {RTY_W{1'b1}}) begin
              retries_r <= retries_r + RTY_W'(1);
            end else begin
              retries_r <= retries_r;
            end
            if (({1'b0, retries_r} + (RTY_W+1)'(1)) == (RTY_W+1)'(MAX_RETRIES)) begin
              state_r <= ST_FAIL;
              fail    <= 1'b1;
            end else begin
              state_r <= ST_RESET_PLL;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // The entry cycle is the first locked sample; STABLE_CYCLES more must follow.
          if (!locked_s) begin
            state_r <= ST_RESET_PLL;
            cnt_r   <= {CNT_W{1'b0}};
            pll_rst <= 1'b1;
          end else if (cnt_r == CNT_W'(STABLE_CYCLES)) begin
            state_r   <= ST_RUN;
            cnt_r     <= {CNT_W{1'b0}};
            sys_rst_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_r   <= ST_RESET_PLL;
            cnt_r     <= {CNT_W{1'b0}};
            retries_r <= {RTY_W{1'b0}};
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FAIL: begin
          if (rearm) begin
            state_r   <= ST_RESET_PLL;
            cnt_r     <= {CNT_W{1'b0}};
            retries_r <= {RTY_W{1'b0}};
            fail      <= 1'b0;
          end else begin
            state_r <= ST_FAIL;
          end
        end
        default: begin
          state_r   <= ST_RESET_PLL;
          cnt_r     <= {CNT_W{1'b0}};
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SUP_LOSS_COUNT_EN
  // Count RUN lock losses, saturating; only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count <= {LOSS_CNT_W{1'b0}};
    end else if ((state_r == ST_RUN) && !locked_s && (loss_count != {LOSS_CNT_W{1'b1}})) begin
      loss_count <= loss_count + LOSS_CNT_W'(1);
    end else begin
      loss_count <= loss_count;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed, table-driven bench for pll_lock_supervisor with small cycle parameters.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       rearm;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       fail;
  logic [2:0] state;
`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] loss_count;
  localparam int N_LOSS = 260;
`else
  localparam int N_LOSS = 2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       locked;
    logic       rearm;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [2:0] state;
  } vec_t;

  vec_t vecs[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .rearm     (rearm),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .fail      (fail),
    .state     (state)
`ifdef PLL_SUP_LOSS_COUNT_EN
    ,
    .loss_count(loss_count)
`endif
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic add_vec(input logic l, input logic r, input logic p, input logic s,
                         input logic f, input logic [2:0] st, input int n);
    vec_t v;
    v = {l, r, p, s, f, st};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    rearm  = 1'b0;
    #12;
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state !== st && n < budget) begin
      step();
      n++;
    end
    check(name, {29'd0, state}, {29'd0, st});
  endtask

  function automatic logic [5:0] outs();
    return {pll_rst, sys_rst_n, fail, state};
  endfunction

  initial begin
    int w;
    logic released;

    // Clean lock: pll_rst for 4 cycles, locked raised 3 cycles after, 12-edge release.
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 9);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 2);
    add_vec(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1);

    do_reset();
    check("reset_outputs", {26'd0, outs()}, {26'd0, 6'b100_000});
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("reset_loss_count", {24'd0, loss_count}, 32'd0);
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      locked = vecs[i].locked;
      rearm  = vecs[i].rearm;
      step();
      check($sformatf("clean_lock_row%0d", i), {26'd0, outs()},
            {26'd0, vecs[i].pll_rst, vecs[i].sys_rst_n, vecs[i].fail, vecs[i].state});
    end
    rearm = 1'b0;

    // Loss in RUN: release drops exactly 3 edges after locked falls.
    locked = 1'b0;
    step();
    check("loss_edge1", {26'd0, outs()}, {26'd0, 6'b010_011});
    step();
    check("loss_edge2", {26'd0, outs()}, {26'd0, 6'b010_011});
    step();
    check("loss_edge3", {26'd0, outs()}, {26'd0, 6'b100_000});
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("loss_count_one", {24'd0, loss_count}, 32'd1);
`endif

    // Timeout and fail: two 20-cycle WAIT windows then FAIL.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wait_state(3'd1, 10, "to_enter_wait");
      w = 1;
      while (state == 3'd1 && w < 100) begin
        step();
        w++;
      end
      check($sformatf("to_window%0d_len", k), w - 1, 32'd20);
    end
    check("to_fail_outputs", {26'd0, outs()}, {26'd0, 6'b101_100});
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    check("rearm_outputs", {26'd0, outs()}, {26'd0, 6'b100_000});

    // Stability glitch after one timeout: must restart, and a single further timeout must FAIL.
    wait_state(3'd1, 10, "gl_enter_wait1");
    wait_state(3'd0, 30, "gl_first_timeout_retry");
    wait_state(3'd1, 10, "gl_enter_wait2");
    locked = 1'b1;
    wait_state(3'd2, 5, "gl_enter_stable");
    step();
    step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    released = 1'b0;
    w = 0;
    while (state != 3'd0 && w < 8) begin
      step();
      if (sys_rst_n || state == 3'd3) released = 1'b1;
      w++;
    end
    check("gl_back_to_reset", {29'd0, state}, 32'd0);
    check("gl_no_release", {31'd0, released}, 32'd0);
    locked = 1'b0;
    wait_state(3'd4, 60, "gl_retries_kept_fail");
    check("gl_fail_flag", {31'd0, fail}, 32'd1);

    // Repeated RUN losses; the counter saturates when present.
    do_reset();
    locked = 1'b1;
    wait_state(3'd3, 40, "sat_first_run");
    for (int k = 0; k < N_LOSS; k++) begin
      locked = 1'b0;
      w = 0;
      while (sys_rst_n && w < 10) begin
        step();
        w++;
      end
      check("sat_drop_seen", {31'd0, sys_rst_n}, 32'd0);
      locked = 1'b1;
      wait_state(3'd3, 40, "sat_relock");
    end
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("loss_count_sat", {24'd0, loss_count}, 32'd255);
`endif

    // Reset mid-STABLE acts asynchronously, without a clock edge.
    locked = 1'b0;
    wait_state(3'd0, 10, "mid_drop_to_reset");
    locked = 1'b1;
    wait_state(3'd2, 20, "mid_enter_stable");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, outs()}, {26'd0, 6'b100_000});
`ifdef PLL_SUP_LOSS_COUNT_EN
    check("async_reset_loss_count", {24'd0, loss_count}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
